// File: rtl/row_policy_pkg.sv
// Shared types and helpers for the row-policy command adapter: policy modes,
// counter word type and saturating arithmetic used by the per-bank predictor.
package row_policy_pkg;

  typedef enum logic [1:0] {
    MODE_OPEN  = 2'd0,
    MODE_CLOSE = 2'd1,
    MODE_ADAPT = 2'd2
  } row_mode_t;

  // Widest predictor counter the helpers support; callers zero-extend into it.
  localparam int unsigned CTR_WORD_BITS = 8;
  localparam int unsigned HIT_BITS      = 16;

  typedef logic [CTR_WORD_BITS-1:0] ctr_word_t;

  function automatic ctr_word_t sat_inc(input ctr_word_t value, input ctr_word_t max);
    return (value >= max) ? max : value + ctr_word_t'(1);
  endfunction

  function automatic ctr_word_t sat_dec(input ctr_word_t value);
    return (value == '0) ? '0 : value - ctr_word_t'(1);
  endfunction

  // The reserved encoding falls back to the adaptive policy.
  function automatic row_mode_t decode_mode(input logic [1:0] raw);
    row_mode_t mode;
    case (raw)
      2'd0:    mode = MODE_OPEN;
      2'd1:    mode = MODE_CLOSE;
      default: mode = MODE_ADAPT;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/cmd_skid_buffer.sv
// Two-entry valid/ready FIFO. Readiness depends only on the registered
// occupancy, so there is no combinational path from pop_ready to push_ready.
module cmd_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  assign push_ready = (count != 2'd2);
  assign pop_valid  = (count != 2'd0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/row_policy_cmd_adapter.sv
// Frontend-to-rank-slice command adapter: decodes commands, attaches an
// auto-precharge prediction from a per-bank row-policy predictor, and buffers.
module row_policy_cmd_adapter
  import row_policy_pkg::*;
#(
  parameter  int unsigned NUM_BANKS = 8,
  parameter  int unsigned ROW_BITS  = 16,
  parameter  int unsigned COL_BITS  = 10,
  parameter  int unsigned DATA_BITS = 64,
  parameter  int unsigned CNT_BITS  = 2,
  localparam int unsigned BANK_BITS = $clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 power_on_rst_n,
  input  logic [1:0]           i_mode,
  input  logic                 i_predictor_clear,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_write,
  input  logic [BANK_BITS-1:0] i_cmd_bank,
  input  logic [ROW_BITS-1:0]  i_cmd_row,
  input  logic [COL_BITS-1:0]  i_cmd_col,
  input  logic [DATA_BITS-1:0] i_cmd_wdata,
  output logic                 o_bk_valid,
  input  logic                 i_bk_ready,
  output logic                 o_bk_write,
  output logic [BANK_BITS-1:0] o_bk_bank,
  output logic [ROW_BITS-1:0]  o_bk_row,
  output logic [COL_BITS-1:0]  o_bk_col,
  output logic [DATA_BITS-1:0] o_bk_wdata,
  output logic                 o_bk_auto_precharge,
  output logic [15:0]          o_hit_count
);

  if (CNT_BITS < 2 || CNT_BITS > CTR_WORD_BITS) begin : g_bad_cnt_bits
    $error("CNT_BITS out of supported range");
  end

  typedef struct packed {
    logic                 write;
    logic [BANK_BITS-1:0] bank;
    logic [ROW_BITS-1:0]  row;
    logic [COL_BITS-1:0]  col;
    logic [DATA_BITS-1:0] wdata;
    logic                 ap;
  } bk_entry_t;

  localparam logic [CNT_BITS-1:0] CTR_INIT = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CTR_MAX  = '1;

  logic [ROW_BITS-1:0] open_row [NUM_BANKS];
  logic [NUM_BANKS-1:0] row_vld;
  logic [CNT_BITS-1:0] ctr [NUM_BANKS];
  logic [HIT_BITS-1:0] hit_count;

  logic                cmd_ready;
  logic                accept;
  logic                hit;
  logic                ap;
  logic [CNT_BITS-1:0] cur_ctr;
  logic [CNT_BITS-1:0] ctr_next;
  row_mode_t           mode;
  bk_entry_t           push_entry;
  bk_entry_t           head;
  logic                head_valid;

  assign accept  = i_cmd_valid && cmd_ready;
  assign mode    = decode_mode(i_mode);
  assign cur_ctr = ctr[i_cmd_bank];
  assign hit     = row_vld[i_cmd_bank] && (open_row[i_cmd_bank] == i_cmd_row);

  // Decision and counter step both come from the pre-update bank state.
  always_comb begin
    ap = 1'b0;
    case (mode)
      MODE_OPEN:  ap = 1'b0;
      MODE_CLOSE: ap = 1'b1;
      default:    ap = (cur_ctr < CTR_INIT);
    endcase
  end

  always_comb begin
    ctr_next = cur_ctr;
    if (hit) begin
      ctr_next = CNT_BITS'(sat_inc(ctr_word_t'(cur_ctr), ctr_word_t'(CTR_MAX)));
    end else begin
      ctr_next = CNT_BITS'(sat_dec(ctr_word_t'(cur_ctr)));
    end
  end

  // Clear wins over the same-cycle update; the accepted command already
  // carries its decision taken from the pre-clear state.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        open_row[b] <= '0;
        ctr[b]      <= CTR_INIT;
      end
      row_vld <= '0;
    end else if (i_predictor_clear) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        open_row[b] <= '0;
        ctr[b]      <= CTR_INIT;
      end
      row_vld <= '0;
    end else if (accept) begin
      open_row[i_cmd_bank] <= i_cmd_row;
      row_vld[i_cmd_bank]  <= 1'b1;
      ctr[i_cmd_bank]      <= ctr_next;
    end
  end

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      hit_count <= '0;
    end else if (accept && hit && (hit_count != '1)) begin
      hit_count <= hit_count + HIT_BITS'(1);
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.write = i_cmd_write;
    push_entry.bank  = i_cmd_bank;
    push_entry.row   = i_cmd_row;
    push_entry.col   = i_cmd_col;
    push_entry.wdata = i_cmd_wdata;
    push_entry.ap    = ap;
  end

  cmd_skid_buffer #(
    .WIDTH ($bits(bk_entry_t))
  ) u_out_buf (
    .clk        (clk),
    .rst_n      (power_on_rst_n),
    .push_valid (i_cmd_valid),
    .push_ready (cmd_ready),
    .push_data  (push_entry),
    .pop_valid  (head_valid),
    .pop_ready  (i_bk_ready),
    .pop_data   (head)
  );

  assign o_cmd_ready         = cmd_ready;
  assign o_bk_valid          = head_valid;
  assign o_bk_write          = head.write;
  assign o_bk_bank           = head.bank;
  assign o_bk_row            = head.row;
  assign o_bk_col            = head.col;
  assign o_bk_wdata          = head.wdata;
  assign o_bk_auto_precharge = head.ap;
  assign o_hit_count         = hit_count;

endmodule

// File: tb/tb_row_policy_cmd_adapter.sv
// Scoreboard bench for row_policy_cmd_adapter: directed row-policy scenarios
// followed by randomized traffic, checked against a per-bank reference model.
module tb_row_policy_cmd_adapter;

  localparam int NB   = 8;
  localparam int RB   = 16;
  localparam int CB   = 10;
  localparam int DB   = 64;
  localparam int CN   = 2;
  localparam int HALF = 1 << (CN - 1);
  localparam int CMAX = (1 << CN) - 1;

  logic          clk = 1'b0;
  logic          power_on_rst_n;
  logic [1:0]    i_mode;
  logic          i_predictor_clear;
  logic          i_cmd_valid;
  logic          o_cmd_ready;
  logic          i_cmd_write;
  logic [2:0]    i_cmd_bank;
  logic [RB-1:0] i_cmd_row;
  logic [CB-1:0] i_cmd_col;
  logic [DB-1:0] i_cmd_wdata;
  logic          o_bk_valid;
  logic          i_bk_ready;
  logic          o_bk_write;
  logic [2:0]    o_bk_bank;
  logic [RB-1:0] o_bk_row;
  logic [CB-1:0] o_bk_col;
  logic [DB-1:0] o_bk_wdata;
  logic          o_bk_auto_precharge;
  logic [15:0]   o_hit_count;

  row_policy_cmd_adapter #(
    .NUM_BANKS (NB),
    .ROW_BITS  (RB),
    .COL_BITS  (CB),
    .DATA_BITS (DB),
    .CNT_BITS  (CN)
  ) dut (
    .clk                 (clk),
    .power_on_rst_n      (power_on_rst_n),
    .i_mode              (i_mode),
    .i_predictor_clear   (i_predictor_clear),
    .i_cmd_valid         (i_cmd_valid),
    .o_cmd_ready         (o_cmd_ready),
    .i_cmd_write         (i_cmd_write),
    .i_cmd_bank          (i_cmd_bank),
    .i_cmd_row           (i_cmd_row),
    .i_cmd_col           (i_cmd_col),
    .i_cmd_wdata         (i_cmd_wdata),
    .o_bk_valid          (o_bk_valid),
    .i_bk_ready          (i_bk_ready),
    .o_bk_write          (o_bk_write),
    .o_bk_bank           (o_bk_bank),
    .o_bk_row            (o_bk_row),
    .o_bk_col            (o_bk_col),
    .o_bk_wdata          (o_bk_wdata),
    .o_bk_auto_precharge (o_bk_auto_precharge),
    .o_hit_count         (o_hit_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          write;
    int          bank;
    int          row;
    int          col;
    logic [63:0] wdata;
    bit          ap;
  } exp_t;

  exp_t sbq[$];
  int   m_row [NB];
  bit   m_vld [NB];
  int   m_ctr [NB];
  int   m_hits;
  int   occ;

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) begin
      m_row[i] = 0;
      m_vld[i] = 1'b0;
      m_ctr[i] = HALF;
    end
  endfunction

  // Stimulus side: model acceptance and predictor behaviour, push expectations.
  always @(negedge clk) begin
    bit   acc;
    bit   iss;
    bit   hit;
    bit   ap;
    int   b;
    exp_t e;
    if (!power_on_rst_n) begin
      model_clear();
      m_hits = 0;
      occ    = 0;
      sbq.delete();
    end else begin
      check("cmd_ready", 64'(o_cmd_ready), 64'(occ < 2));
      check("bk_valid", 64'(o_bk_valid), 64'(occ > 0));
      check("hit_count", 64'(o_hit_count), 64'(m_hits));
      acc = i_cmd_valid && (occ < 2);
      iss = (occ > 0) && i_bk_ready;
      if (acc) begin
        b   = int'(i_cmd_bank);
        hit = m_vld[b] && (m_row[b] == int'(i_cmd_row));
        case (i_mode)
          2'd0:    ap = 1'b0;
          2'd1:    ap = 1'b1;
          default: ap = (m_ctr[b] < HALF);
        endcase
        e.write = i_cmd_write;
        e.bank  = b;
        e.row   = int'(i_cmd_row);
        e.col   = int'(i_cmd_col);
        e.wdata = i_cmd_wdata;
        e.ap    = ap;
        sbq.push_back(e);
        if (hit) begin
          m_ctr[b] = (m_ctr[b] >= CMAX) ? CMAX : m_ctr[b] + 1;
          if (m_hits < 65535) m_hits++;
        end else begin
          m_ctr[b] = (m_ctr[b] <= 0) ? 0 : m_ctr[b] - 1;
        end
        m_row[b] = int'(i_cmd_row);
        m_vld[b] = 1'b1;
      end
      if (i_predictor_clear) model_clear();
      occ = occ + int'(acc) - int'(iss);
    end
  end

  // Monitor side: every issued backend command must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (power_on_rst_n && o_bk_valid && i_bk_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_unexpected: got bank %0d row %0h expected no command at %0t",
                 o_bk_bank, o_bk_row, $time);
      end else begin
        e = sbq.pop_front();
        check("bk_write", 64'(o_bk_write), 64'(e.write));
        check("bk_bank", 64'(o_bk_bank), 64'(e.bank));
        check("bk_row", 64'(o_bk_row), 64'(e.row));
        check("bk_col", 64'(o_bk_col), 64'(e.col));
        check("bk_wdata", o_bk_wdata, e.wdata);
        check("bk_ap", 64'(o_bk_auto_precharge), 64'(e.ap));
      end
    end
  end

  bit rand_rdy = 1'b0;

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      i_bk_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input bit w, input int bank, input int row, input int mode, input bit clr);
    bit accepted = 1'b0;
    i_cmd_valid       = 1'b1;
    i_cmd_write       = w;
    i_cmd_bank        = 3'(bank);
    i_cmd_row         = RB'(row);
    i_cmd_col         = CB'($urandom);
    i_cmd_wdata       = {$urandom, $urandom};
    i_mode            = 2'(mode);
    i_predictor_clear = clr;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (o_cmd_ready) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no accept expected accept within 64 cycles");
    end
    @(posedge clk);
    #1;
    i_cmd_valid       = 1'b0;
    i_predictor_clear = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (occ == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_occupancy", 64'(occ), 64'd0);
    check("drain_queue", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    power_on_rst_n    = 1'b0;
    i_mode            = 2'd2;
    i_predictor_clear = 1'b0;
    i_cmd_valid       = 1'b0;
    i_cmd_write       = 1'b0;
    i_cmd_bank        = '0;
    i_cmd_row         = '0;
    i_cmd_col         = '0;
    i_cmd_wdata       = '0;
    i_bk_ready        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    check("rst_bk_valid", 64'(o_bk_valid), 64'd0);
    check("rst_bk_fields", 64'({o_bk_write, o_bk_bank, o_bk_row, o_bk_col}), 64'd0);
    check("rst_bk_wdata", o_bk_wdata, 64'd0);
    check("rst_bk_ap", 64'(o_bk_auto_precharge), 64'd0);
    check("rst_hit_count", 64'(o_hit_count), 64'd0);
    @(negedge clk);
    #1;
    power_on_rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Adaptive warm-up on one row: miss, then two hits.
    repeat (3) send(1'b1, 3, 'h12, 2, 1'b0);
    // Ping-pong rows drive the counter to zero; an untouched bank stays weakly open.
    send(1'b0, 0, 'h1, 2, 1'b0);
    send(1'b0, 0, 'h2, 2, 1'b0);
    send(1'b0, 0, 'h1, 2, 1'b0);
    send(1'b0, 0, 'h2, 2, 1'b0);
    send(1'b0, 5, 'h33, 2, 1'b0);
    // Fixed policies still train the counter.
    repeat (4) send(1'b1, 1, 'h7, 0, 1'b0);
    repeat (4) send(1'b0, 1, 'h7, 1, 1'b0);
    send(1'b0, 1, 'h7, 2, 1'b0);
    drain();

    // Backpressure: fill the buffer, stall a third, release.
    i_bk_ready = 1'b0;
    send(1'b1, 4, 'h40, 2, 1'b0);
    send(1'b0, 4, 'h41, 2, 1'b0);
    fork
      send(1'b1, 6, 'h60, 2, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1;
        i_bk_ready = 1'b1;
      end
    join
    drain();

    // Clear coinciding with a hit on a saturated bank.
    repeat (3) send(1'b0, 2, 'h9, 2, 1'b0);
    send(1'b0, 2, 'h9, 2, 1'b1);
    send(1'b0, 2, 'h9, 2, 1'b0);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom), $urandom_range(0, NB - 1), $urandom_range(0, 3),
           $urandom_range(0, 3), ($urandom_range(0, 31) == 0));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    i_bk_ready = 1'b1;
    drain();

    // Asynchronous reset with two buffered entries.
    i_bk_ready = 1'b0;
    send(1'b1, 3, 'h12, 2, 1'b0);
    send(1'b1, 3, 'h12, 2, 1'b0);
    @(posedge clk);
    #2;
    power_on_rst_n = 1'b0;
    #1;
    check("async_rst_bk_valid", 64'(o_bk_valid), 64'd0);
    check("async_rst_hit_count", 64'(o_hit_count), 64'd0);
    check("async_rst_cmd_ready", 64'(o_cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    #1;
    power_on_rst_n = 1'b1;
    i_bk_ready     = 1'b1;
    @(posedge clk);
    #1;
    send(1'b0, 3, 'h12, 2, 1'b0);
    send(1'b0, 3, 'h12, 2, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
